phys_tick_sched: RTL and testbench
==================================

// Module: phys_tick_sched
// PURPOSE
//  Game-tick scheduler for the physics datapath. Generates the periodic physics tick
//  (100 Hz at 6.5 MHz) and, on every tick, serialises access to the shared position/
//  gravity update unit among N_REQ movement controllers (players, enemies), round-robin.
//  Sits between the clock domain root and the per-character movement controllers.
// PARAMETERS
//  N_REQ        4       number of requesters (>=2)
//  TICK_CYCLES  65000   clk cycles per physics tick (CLK_FREQ/TIC)
//  TIMEOUT      256     max cycles a grant is held waiting for done
//  IDW          $clog2(N_REQ)  width of grant index
// PORTS
//  clk          in   1      clock
//  rst          in   1      reset, synchronous, active-high
//  req          in   N_REQ  requester i needs an update this tick (level)
//  done         in   N_REQ  requester i finished its update (1-cycle pulse)
//  tick         out  1      1-cycle pulse, once per TICK_CYCLES
//  gnt          out  N_REQ  one-hot grant, held until done/timeout
//  gnt_id       out  IDW    index of current grant (valid when |gnt)
//  busy         out  1      service round in progress (state != IDLE)
//  err_timeout  out  1      1-cycle pulse: grant revoked by timeout
//  overrun      out  1      1-cycle pulse: tick arrived while busy
//  overrun_cnt  out  8      saturating count of overruns
// BEHAVIOUR
//  Reset: all outputs 0, tick counter 0, rr_ptr 0, pend 0, state IDLE.
//  Tick counter counts 0..TICK_CYCLES-1, wraps; tick=1 in the cycle cnt==TICK_CYCLES-1.
//  FSM states IDLE, SCAN, WAIT:
//   IDLE: on tick=1 latch pend<=req, go SCAN. Requests raised later wait for next tick.
//   SCAN: pend==0 -> IDLE. Else pick first set pend bit at/after rr_ptr (cyclic),
//     register gnt one-hot and gnt_id, clear wait counter, go WAIT.
//   WAIT: gnt held stable. done[gnt_id]=1 -> gnt<=0, pend[gnt_id]<=0,
//     rr_ptr<=(gnt_id+1) mod N_REQ, go SCAN. Wait counter reaching TIMEOUT-1 without
//     done -> same actions plus err_timeout=1 for one cycle.
//  Latency: tick in cycle T -> SCAN in T+1 -> gnt visible from T+2. Done in cycle D ->
//   gnt low at D+1, next grant at D+2. Dead cycle between grants is mandatory.
//  done on non-granted lines, or while not in WAIT, is ignored.
//  req dropped after latch does not cancel the pending service.
//  Overrun: tick=1 while state!=IDLE -> overrun=1 for that cycle, overrun_cnt+1
//   (saturate at 255); tick is dropped, current round continues unaffected.
//  rr_ptr persists across ticks: fairness across rounds, not just within one.
//  Never more than one gnt bit set; gnt==0 whenever state!=WAIT.
//  rst mid-round: gnt drops next cycle, pend/rr_ptr/counters cleared, no done needed.
// TESTING  (sim with TICK_CYCLES=20, TIMEOUT=8, N_REQ=4)
//  1. rst, req=0 -> tick pulses every 20 cycles, first at cycle 19; gnt stays 0, busy 1 cycle.
//  2. req=4'b1011, done returned 3 cycles after each grant -> grant order 0,1,3;
//     gnt high at T+2; busy drops after last done; rr_ptr=0 afterwards.
//  3. Next tick with req=4'b1011 again -> order 0,1,3 again (rr_ptr=0); with rr_ptr
//     forced to 2 via prior round serving only 1 -> order 3,0,1.
//  4. req=4'b0100, done never -> gnt[2] held 8 cycles, err_timeout pulse, busy falls.
//  5. done held off past next tick -> overrun pulse at tick, overrun_cnt=1; 300
//     overruns -> overrun_cnt=255.
//  6. rst asserted while gnt=4'b0010 -> gnt=0, busy=0, overrun_cnt=0 next cycle.

Source files
------------

// File: rtl/phys_tick_sched.sv
// Physics tick generator plus round-robin arbiter for the shared position/gravity
// update unit; one service round per tick, each grant held until done or timeout.
module phys_tick_sched #(
    parameter int N_REQ       = 4,
    parameter int TICK_CYCLES = 65000,
    parameter int TIMEOUT     = 256,
    parameter int IDW         = $clog2(N_REQ)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    input  logic [N_REQ-1:0] done,
    output logic             tick,
    output logic [N_REQ-1:0] gnt,
    output logic [IDW-1:0]   gnt_id,
    output logic             busy,
    output logic             err_timeout,
    output logic             overrun,
    output logic [7:0]       overrun_cnt
);

    localparam int CW = $clog2(TICK_CYCLES);
    localparam int WW = $clog2(TIMEOUT + 1);
    localparam int SW = IDW + 1;
    localparam logic [CW-1:0]  TICK_LAST = CW'(TICK_CYCLES - 1);
    localparam logic [WW-1:0]  WAIT_LAST = WW'(TIMEOUT - 1);
    localparam logic [IDW-1:0] LAST_ID   = IDW'(N_REQ - 1);
    localparam logic [SW-1:0]  N_WIDE    = SW'(N_REQ);

    typedef enum logic [1:0] {IDLE, SCAN, WAIT} state_t;

    state_t           state, state_nxt;
    logic [CW-1:0]    cnt;
    logic [N_REQ-1:0] pend, pend_nxt;
    logic [N_REQ-1:0] gnt_nxt;
    logic [IDW-1:0]   rr_ptr, rr_ptr_nxt;
    logic [IDW-1:0]   gnt_id_nxt;
    logic [IDW-1:0]   pick;
    logic [IDW-1:0]   idx;
    logic [SW-1:0]    sum;
    logic [WW-1:0]    wcnt, wcnt_nxt;
    logic             err_nxt;
    logic             found;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (cnt == TICK_LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tick    = (cnt == TICK_LAST);
    assign busy    = (state != IDLE);
    assign overrun = tick && busy;

    // Cyclic search starting at rr_ptr; sum stays below 2*N_REQ so one subtraction wraps it.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        idx   = '0;
        sum   = '0;
        for (int i = 0; i < N_REQ; i++) begin
            sum = {1'b0, rr_ptr} + SW'(i);
            if (sum >= N_WIDE) begin
                sum = sum - N_WIDE;
            end
            idx = sum[IDW-1:0];
            if (!found && pend[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end
    end

    always_comb begin
        state_nxt  = state;
        pend_nxt   = pend;
        rr_ptr_nxt = rr_ptr;
        gnt_nxt    = gnt;
        gnt_id_nxt = gnt_id;
        wcnt_nxt   = wcnt;
        err_nxt    = 1'b0;
        unique case (state)
            IDLE: begin
                if (tick) begin
                    pend_nxt  = req;
                    state_nxt = SCAN;
                end
            end
            SCAN: begin
                if (!found) begin
                    state_nxt = IDLE;
                end else begin
                    gnt_nxt       = '0;
                    gnt_nxt[pick] = 1'b1;
                    gnt_id_nxt    = pick;
                    wcnt_nxt      = '0;
                    state_nxt     = WAIT;
                end
            end
            WAIT: begin
                // Done wins over a timeout landing in the same cycle.
                if (done[gnt_id] || (wcnt == WAIT_LAST)) begin
                    gnt_nxt          = '0;
                    pend_nxt[gnt_id] = 1'b0;
                    rr_ptr_nxt       = (gnt_id == LAST_ID) ? '0 : gnt_id + 1'b1;
                    err_nxt          = !done[gnt_id];
                    state_nxt        = SCAN;
                end else begin
                    wcnt_nxt = wcnt + 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            pend        <= '0;
            rr_ptr      <= '0;
            gnt         <= '0;
            gnt_id      <= '0;
            wcnt        <= '0;
            err_timeout <= 1'b0;
            overrun_cnt <= '0;
        end else begin
            state       <= state_nxt;
            pend        <= pend_nxt;
            rr_ptr      <= rr_ptr_nxt;
            gnt         <= gnt_nxt;
            gnt_id      <= gnt_id_nxt;
            wcnt        <= wcnt_nxt;
            err_timeout <= err_nxt;
            if (overrun && (overrun_cnt != 8'hFF)) begin
                overrun_cnt <= overrun_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_phys_tick_sched.sv
// Bench for phys_tick_sched: directed scenario tasks plus random traffic, all checked
// cycle by cycle against a queue-based model of a service round.
module tb_phys_tick_sched;

    localparam int N    = 4;
    localparam int TICK = 20;
    localparam int TMO  = 8;

    logic         clk;
    logic         rst;
    logic [N-1:0] req;
    logic [N-1:0] done;
    logic         tick;
    logic [N-1:0] gnt;
    logic [1:0]   gnt_id;
    logic         busy;
    logic         err_timeout;
    logic         overrun;
    logic [7:0]   overrun_cnt;

    int n_cmp;
    int n_fail;

    int m_cyc;
    int m_cur;
    int m_start;
    int m_rr;
    int m_ocnt;
    bit m_busy;
    bit m_err;
    int m_q[$];

    logic [17:0] dut_vec;

    phys_tick_sched #(
        .N_REQ(N),
        .TICK_CYCLES(TICK),
        .TIMEOUT(TMO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .req(req),
        .done(done),
        .tick(tick),
        .gnt(gnt),
        .gnt_id(gnt_id),
        .busy(busy),
        .err_timeout(err_timeout),
        .overrun(overrun),
        .overrun_cnt(overrun_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign dut_vec = {tick, gnt, (|gnt) ? gnt_id : 2'b00, busy, err_timeout, overrun, overrun_cnt};

    // Model: at a tick the whole round is queued in cyclic order from the persistent pointer.
    task automatic model_step();
        bit tick_now;
        if (rst) begin
            m_cyc = 0; m_cur = -1; m_start = 0; m_rr = 0; m_ocnt = 0;
            m_busy = 0; m_err = 0; m_q.delete();
            return;
        end
        tick_now = (m_cyc % TICK) == TICK - 1;
        if (tick_now && m_busy && m_ocnt < 255) m_ocnt++;
        m_err = 0;
        if (m_cur >= 0) begin
            if (done[m_cur] || (m_cyc - m_start == TMO - 1)) begin
                m_err = !done[m_cur];
                m_rr  = (m_cur + 1) % N;
                m_cur = -1;
            end
        end else if (m_busy) begin
            if (m_q.size() == 0) begin
                m_busy = 0;
            end else begin
                m_cur   = m_q.pop_front();
                m_start = m_cyc + 1;
            end
        end else if (tick_now) begin
            for (int i = 0; i < N; i++) begin
                if (req[(m_rr + i) % N]) m_q.push_back((m_rr + i) % N);
            end
            m_busy = 1;
        end
        m_cyc++;
    endtask

    function automatic logic [17:0] exp_vec();
        logic         t;
        logic [N-1:0] g;
        logic [1:0]   id;
        t  = (m_cyc % TICK) == TICK - 1;
        g  = '0;
        id = '0;
        if (m_cur >= 0) begin
            g[m_cur] = 1'b1;
            id       = 2'(m_cur);
        end
        return {t, g, id, m_busy, m_err, t & m_busy, 8'(m_ocnt)};
    endfunction

    task automatic next_cycle();
        model_step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        int ticks;
        int busys;
        int first_tick;
        rst = 1'b1; req = '0; done = '0;
        repeat (3) next_cycle();
        rst = 1'b0;
        n_cmp++;
        if (dut_vec !== 18'h0) begin
            n_fail++; $display("[TB] FAIL reset_state got=%h want=%h", dut_vec, 18'h0);
        end
        ticks = 0; busys = 0; first_tick = -1;
        for (int c = 0; c < 45; c++) begin
            n_cmp++;
            if (dut_vec !== exp_vec()) begin
                n_fail++; $display("[TB] FAIL idle_cycle c=%0d got=%h want=%h", c, dut_vec, exp_vec());
            end
            if (tick === 1'b1) begin
                ticks++;
                if (first_tick < 0) first_tick = c;
            end
            if (busy === 1'b1) busys++;
            next_cycle();
        end
        n_cmp++;
        if (first_tick != 19) begin
            n_fail++; $display("[TB] FAIL first_tick got=%0d want=19", first_tick);
        end
        n_cmp++;
        if (ticks != 2) begin
            n_fail++; $display("[TB] FAIL tick_count got=%0d want=2", ticks);
        end
        n_cmp++;
        if (busys != 2) begin
            n_fail++; $display("[TB] FAIL empty_round_busy got=%0d want=2", busys);
        end
    endtask

    task automatic test_round_robin();
        logic [3:0] reqs [4] = '{4'b1011, 4'b1011, 4'b0010, 4'b1011};
        int         want [4] = '{'h013, 'h013, 'h1, 'h301};
        int ord;
        int tick_c;
        int first_c;
        int g_c;
        bit fin;
        for (int rd = 0; rd < 4; rd++) begin
            ord = 0; tick_c = -1; first_c = -1; g_c = -1; fin = 0;
            req = reqs[rd];
            for (int c = 0; c < 80 && !fin; c++) begin
                n_cmp++;
                if (dut_vec !== exp_vec()) begin
                    n_fail++; $display("[TB] FAIL rr_cycle rd=%0d c=%0d got=%h want=%h", rd, c, dut_vec, exp_vec());
                end
                if (tick_c >= 0 && c > tick_c && busy === 1'b0) begin
                    fin = 1;
                end else begin
                    if (tick === 1'b1 && tick_c < 0) tick_c = c;
                    if (gnt !== '0 && g_c < 0) begin
                        g_c = c;
                        ord = ord * 16 + int'(gnt_id);
                        if (first_c < 0) first_c = c;
                    end
                    if (gnt === '0) g_c = -1;
                    done = (g_c >= 0 && c - g_c == 3) ? gnt : '0;
                    next_cycle();
                end
            end
            done = '0;
            n_cmp++;
            if (!fin) begin
                n_fail++; $display("[TB] FAIL rr_round_end rd=%0d got=busy want=idle", rd);
            end
            n_cmp++;
            if (ord != want[rd]) begin
                n_fail++; $display("[TB] FAIL rr_order rd=%0d got=%0h want=%0h", rd, ord, want[rd]);
            end
            n_cmp++;
            if (first_c - tick_c != 2) begin
                n_fail++; $display("[TB] FAIL grant_latency rd=%0d got=%0d want=2", rd, first_c - tick_c);
            end
        end
    endtask

    task automatic test_timeout();
        int held;
        int errs;
        int tick_c;
        bit fin;
        req = 4'b0100; done = '0;
        held = 0; errs = 0; tick_c = -1; fin = 0;
        for (int c = 0; c < 80 && !fin; c++) begin
            n_cmp++;
            if (dut_vec !== exp_vec()) begin
                n_fail++; $display("[TB] FAIL tmo_cycle c=%0d got=%h want=%h", c, dut_vec, exp_vec());
            end
            if (tick_c >= 0 && c > tick_c && busy === 1'b0) begin
                fin = 1;
            end else begin
                if (tick === 1'b1 && tick_c < 0) tick_c = c;
                if (gnt === 4'b0100) held++;
                if (err_timeout === 1'b1) errs++;
                next_cycle();
            end
        end
        n_cmp++;
        if (!fin) begin
            n_fail++; $display("[TB] FAIL tmo_round_end got=busy want=idle");
        end
        n_cmp++;
        if (held != TMO) begin
            n_fail++; $display("[TB] FAIL tmo_hold got=%0d want=%0d", held, TMO);
        end
        n_cmp++;
        if (errs != 1) begin
            n_fail++; $display("[TB] FAIL tmo_err_pulses got=%0d want=1", errs);
        end
    endtask

    task automatic test_overrun();
        int ovr;
        int first_cnt;
        req = 4'b1111; done = '0;
        ovr = 0; first_cnt = -1;
        for (int c = 0; c < 15000 && ovr < 300; c++) begin
            n_cmp++;
            if (dut_vec !== exp_vec()) begin
                n_fail++; $display("[TB] FAIL ovr_cycle c=%0d got=%h want=%h", c, dut_vec, exp_vec());
            end
            if (ovr == 1 && first_cnt < 0 && overrun !== 1'b1) first_cnt = int'(overrun_cnt);
            if (overrun === 1'b1) ovr++;
            next_cycle();
        end
        n_cmp++;
        if (ovr != 300) begin
            n_fail++; $display("[TB] FAIL ovr_pulses got=%0d want=300", ovr);
        end
        n_cmp++;
        if (first_cnt != 1) begin
            n_fail++; $display("[TB] FAIL ovr_first_count got=%0d want=1", first_cnt);
        end
        n_cmp++;
        if (overrun_cnt !== 8'd255) begin
            n_fail++; $display("[TB] FAIL ovr_saturate got=%0d want=255", overrun_cnt);
        end
    endtask

    task automatic test_mid_reset();
        bit found;
        found = 0;
        for (int c = 0; c < 100 && !found; c++) begin
            n_cmp++;
            if (dut_vec !== exp_vec()) begin
                n_fail++; $display("[TB] FAIL mid_cycle c=%0d got=%h want=%h", c, dut_vec, exp_vec());
            end
            if (gnt === 4'b0010) found = 1;
            else next_cycle();
        end
        n_cmp++;
        if (!found) begin
            n_fail++; $display("[TB] FAIL mid_find_grant got=%b want=0010", gnt);
        end
        rst = 1'b1;
        next_cycle();
        n_cmp++;
        if (gnt !== 4'b0000) begin
            n_fail++; $display("[TB] FAIL mid_rst_gnt got=%b want=0000", gnt);
        end
        n_cmp++;
        if (busy !== 1'b0) begin
            n_fail++; $display("[TB] FAIL mid_rst_busy got=%b want=0", busy);
        end
        n_cmp++;
        if (overrun_cnt !== 8'd0) begin
            n_fail++; $display("[TB] FAIL mid_rst_ovr_cnt got=%0d want=0", overrun_cnt);
        end
        rst = 1'b0;
        req = '0;
    endtask

    task automatic test_random();
        for (int c = 0; c < 3000; c++) begin
            n_cmp++;
            if (dut_vec !== exp_vec()) begin
                n_fail++; $display("[TB] FAIL rand_cycle c=%0d got=%h want=%h", c, dut_vec, exp_vec());
            end
            if ($urandom_range(0, 3) == 0) req = 4'($urandom);
            done = '0;
            if (gnt !== '0 && $urandom_range(0, 3) == 0) done = gnt;
            if ($urandom_range(0, 7) == 0) done[$urandom_range(0, N - 1)] = 1'b1;
            rst = ($urandom_range(0, 999) == 0);
            next_cycle();
        end
        rst = 1'b0;
        done = '0;
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog got=timeout want=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        n_cmp = 0; n_fail = 0;
        rst = 1'b1; req = '0; done = '0;
        m_cur = -1; m_cyc = 0; m_start = 0; m_rr = 0; m_ocnt = 0; m_busy = 0; m_err = 0;
        @(negedge clk);
        test_reset();
        test_round_robin();
        test_timeout();
        test_overrun();
        test_mid_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
